// File: rtl/serial_parity_receiver_pkg.sv
// Shared types and frame constants for the serial parity receiver.
// Imported by the receiver top level and its testbench.
package serial_parity_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_parity_receiver_if.sv
// Bit-strobe input and status/data output bundle of the serial parity receiver.
// The master drives the serial line; the slave is the receiver.
interface serial_parity_receiver_if #(
    parameter int N = 8
);
    logic         bit_en;
    logic         serial_in;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         parity_err;
    logic         frame_err;
    logic         busy;

    modport master (
        output bit_en, serial_in,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  bit_en, serial_in,
        output data_out, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/serial_parity_receiver_parity_check_core.sv
// Combinational parity comparison: flags a mismatch between the received
// parity bit and the parity expected for the data word.
module parity_check_core #(
    parameter int N   = 8,
    parameter int ODD = 0
) (
    input  logic [N-1:0] data,
    input  logic         rx_par,
    output logic         mismatch
);
    localparam logic ODD_BIT = (ODD != 0);

    logic exp_par;

    assign exp_par  = (^data) ^ ODD_BIT;
    assign mismatch = rx_par ^ exp_par;
endmodule

// File: rtl/serial_parity_receiver.sv
// Frame receiver: start bit, N data bits LSB first, parity bit, stop bit.
// Status pulses are registered and appear one clock after the stop-bit sample.
module serial_parity_receiver
    import serial_parity_receiver_pkg::*;
#(
    parameter int N   = 8,
    parameter int ODD = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    serial_parity_receiver_if.slave  bus
);
    localparam int CNT_W = $clog2(N + 1);

    state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0] shreg;
    logic         rx_par;
    logic         mismatch;

    logic [N-1:0] data_out;
    logic         data_valid;
    logic         parity_err;
    logic         frame_err;
    logic         busy;

    parity_check_core #(
        .N   (N),
        .ODD (ODD)
    ) u_parity (
        .data     (shreg),
        .rx_par   (rx_par),
        .mismatch (mismatch)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            rx_par     <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (bus.bit_en) begin
                case (state)
                    IDLE: begin
                        if (bus.serial_in == START_BIT) begin
                            state <= DATA;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        // Right shift so the first (LSB) bit ends up in bit 0.
                        shreg <= (shreg >> 1) | (N'(bus.serial_in) << (N - 1));
                        if (cnt == CNT_W'(N - 1)) begin
                            state <= PARITY;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        rx_par <= bus.serial_in;
                        state  <= STOP;
                    end
                    STOP: begin
                        if (bus.serial_in == STOP_BIT) begin
                            data_out   <= shreg;
                            data_valid <= 1'b1;
                            parity_err <= mismatch;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.parity_err = parity_err;
    assign bus.frame_err  = frame_err;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_serial_parity_receiver.sv
// Scoreboard bench for serial_parity_receiver: an even-parity and an odd-parity
// instance driven with directed frames; a monitor checks every status pulse.
module tb_serial_parity_receiver;
    import serial_parity_receiver_pkg::*;

    localparam int N = 8;

    typedef struct packed {
        logic         frame;
        logic [N-1:0] data;
        logic         perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    serial_parity_receiver_if #(.N(N)) bus0 ();
    serial_parity_receiver_if #(.N(N)) bus1 ();

    serial_parity_receiver #(.N(N), .ODD(0)) u_even (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    serial_parity_receiver #(.N(N), .ODD(1)) u_odd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    task automatic check_out(input int idx, input logic dv, input logic pe,
                             input logic fe, input logic [N-1:0] d);
        exp_t e;
        logic [N+2:0] got, req;
        if (!(dv || fe)) return;
        tests++;
        if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
            fails++;
            $display("FAIL unexpected_pulse dut%0d: dv=%b pe=%b fe=%b data=%h, required no pulse",
                     idx, dv, pe, fe, d);
            return;
        end
        if (idx == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        got = {fe, dv, pe, d};
        req = {e.frame, ~e.frame, e.perr & ~e.frame, e.data};
        if (got !== req) begin
            fails++;
            $display("FAIL frame_result dut%0d: got fe/dv/pe/data=%b/%b/%b/%h, required %b/%b/%b/%h",
                     idx, fe, dv, pe, d, req[N+2], req[N+1], req[N], req[N-1:0]);
        end
    endtask

    // Monitor: runs independently of stimulus, pops one expectation per pulse.
    always @(negedge clk) begin
        check_out(0, bus0.data_valid, bus0.parity_err, bus0.frame_err, bus0.data_out);
        check_out(1, bus1.data_valid, bus1.parity_err, bus1.frame_err, bus1.data_out);
    end

    task automatic drive(input int idx, input logic en, input logic b);
        if (idx == 0) begin
            bus0.bit_en    = en;
            bus0.serial_in = b;
        end else begin
            bus1.bit_en    = en;
            bus1.serial_in = b;
        end
    endtask

    task automatic send_bit(input int idx, input logic b, input int period,
                            input logic chk, input logic exp_busy);
        logic bsy;
        for (int k = 0; k < period; k++) begin
            @(negedge clk);
            drive(idx, (k == period - 1), b);
        end
        @(posedge clk);
        #1;
        if (chk) begin
            bsy = (idx == 0) ? bus0.busy : bus1.busy;
            tests++;
            if (bsy !== exp_busy) begin
                fails++;
                $display("FAIL busy dut%0d: got %b, required %b", idx, bsy, exp_busy);
            end
        end
    endtask

    task automatic send_frame(input int idx, input logic [N-1:0] data, input logic par,
                              input logic stop, input int period,
                              input logic [N-1:0] exp_data, input logic exp_perr);
        exp_t e;
        e.frame = ~stop;
        e.data  = exp_data;
        e.perr  = exp_perr;
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
        send_bit(idx, START_BIT, period, 1'b1, 1'b1);
        for (int i = 0; i < N; i++) send_bit(idx, data[i], period, 1'b1, 1'b1);
        send_bit(idx, par, period, 1'b1, 1'b1);
        send_bit(idx, stop, period, 1'b1, 1'b0);
    endtask

    task automatic idle(input int idx, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            drive(idx, 1'b1, 1'b1);
        end
        @(negedge clk);
        drive(idx, 1'b0, 1'b1);
    endtask

    task automatic check_reset_state(input string name);
        tests++;
        if ({bus0.busy, bus0.data_valid, bus0.parity_err, bus0.frame_err, bus0.data_out} !== '0 ||
            {bus1.busy, bus1.data_valid, bus1.parity_err, bus1.frame_err, bus1.data_out} !== '0) begin
            fails++;
            $display("FAIL %s: got dut0 busy/dv/pe/fe/data=%b/%b/%b/%b/%h dut1=%b/%b/%b/%b/%h, required all zero",
                     name, bus0.busy, bus0.data_valid, bus0.parity_err, bus0.frame_err, bus0.data_out,
                     bus1.busy, bus1.data_valid, bus1.parity_err, bus1.frame_err, bus1.data_out);
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Even parity, bit_en every cycle.
        send_frame(0, 8'hA5, 1'b0, 1'b1, 1, 8'hA5, 1'b0);
        idle(0, 2);
        send_frame(0, 8'hA5, 1'b1, 1'b1, 1, 8'hA5, 1'b1);
        idle(0, 2);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1, 8'h3C, 1'b0);
        send_frame(0, 8'h81, 1'b0, 1'b0, 1, 8'h3C, 1'b0);
        idle(0, 2);

        // Sparse bit strobe: one bit_en in four cycles.
        send_frame(0, 8'h5A, 1'b0, 1'b1, 4, 8'h5A, 1'b0);
        idle(0, 2);

        // Abort a frame after four data bits with a reset pulse.
        send_bit(0, START_BIT, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1, 1, 1'b0, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_state("reset_mid_frame");
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(0, 8'h0F, 1'b0, 1'b1, 1, 8'h0F, 1'b0);
        idle(0, 2);

        // Odd parity, three frames back to back with no idle bit.
        send_frame(1, 8'h01, 1'b0, 1'b1, 1, 8'h01, 1'b0);
        send_frame(1, 8'h03, 1'b1, 1'b1, 1, 8'h03, 1'b0);
        send_frame(1, 8'h03, 1'b0, 1'b1, 1, 8'h03, 1'b1);
        idle(1, 3);

        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            fails++;
            $display("FAIL missing_pulse: got %0d/%0d expectations outstanding, required 0/0",
                     q0.size(), q1.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
